sprite_dma: RTL and testbench
=============================

# sprite_dma

Agnus-side sprite DMA engine: the initiator that fetches sprite control and image words from chip RAM and delivers them to the Denise sprite registers SPRxPOS/CTL/DATA/DATB at 0x140–0x17E. It holds the eight SPRxPT pointers and a per-sprite vertical state machine. It also drives a chip-bus request, word address and destination register address in eight fixed pairs of horizontal slots per line.

## Interface
- SLOT_BASE, 9'h02A: hpos of sprite 0 first-word slot. Sprite n uses SLOT_BASE+8n (word 0) and SLOT_BASE+8n+4 (word 1).
- VBSTOP, 11'd25: vpos at which all sprites are forced to fetch control words.
- clk  in  1  bus clock, one hpos step per cycle.
- reset  in  1  reset, synchronous, active-high; clock clk.
- hpos  in  9  horizontal beam counter.
- vpos  in  11  vertical beam counter.
- dmaena  in  1  sprite DMA enable (DMACON SPREN & DMAEN).
- reg_address_in  in  8  register bus address [8:1], covering CPU, copper and this block's own write-back.
- data_in  in  16  register bus data.
- dma  out  1  chip-bus slot taken by sprite DMA this cycle.
- address_out  out  20  chip RAM word address [20:1].
- reg_address_out  out  8  destination register [8:1]. 8'hFF means idle.

## Operation
- Pointer registers: SPRxPTH at 0x120+4n loads pt[20:16] from data_in[4:0]. SPRxPTL at 0x122+4n loads pt[15:1] from data_in[15:1].
- Snoop decode, any source:
  - SPRxPOS: vstart[7:0] from data_in[15:8].
  - SPRxCTL: vstop[7:0] from data_in[15:8], vstart[8] from data_in[2], vstop[8] from data_in[1].
- Per-sprite states: IDLE, CTL, WAIT, ACTIVE. The state is evaluated at the word-0 slot, and the whole line's action is latched there.
  - IDLE: no fetch.
  - CTL: fetch POS at word 0, then CTL at word 1. Go to WAIT at the end of word 1.
  - WAIT: if vpos==vstart, fetch DATB at word 0, then DATA at word 1, and go to ACTIVE. Otherwise no fetch. DATA is fetched last because writing DATA arms the sprite.
  - ACTIVE: if vpos==vstop, fetch POS/CTL and go to WAIT. Otherwise fetch DATB/DATA.
- On hpos==0 with vpos==VBSTOP, every sprite goes to CTL.
- Each asserted fetch drives address_out = pt and reg_address_out = 0xA0+4n+{0,1,2,3} (POS, CTL, DATA, DATB). pt increments by one word at the end of the slot.
- dmaena low at a word-0 slot: no fetch for that sprite this line, and state and pointer are unchanged. dmaena is sampled at each slot, so a fetch pair can be cut after word 0. The state then still advances as if the pair completed.
- vstart==vstop after a control fetch: WAIT matches vstart and goes to ACTIVE. On the following line the vstop compare cannot match again, so the sprite stays ACTIVE until the next VBSTOP.

## Timing
- dma, address_out and reg_address_out are combinational from registered state, pointers and hpos. They are valid in the slot cycle itself, with zero latency.
- State and pointer updates take effect at the clock edge that ends the slot.
- A pointer write in the same cycle as an increment: the write wins and no increment occurs. A PTH write only touches pt[20:16]; the increment still applies to pt[15:1]. The carry into [20:16] is then discarded.
- Snoop of the block's own POS/CTL write-back: new vstart/vstop are visible from the next line.
- Reset values: dma=0, address_out=0, reg_address_out=8'hFF, all pt=0, all vstart/vstop=0, all states IDLE.
- Reset mid-slot: outputs are idle in the next cycle.
- Outside slot cycles: dma=0, address_out=0, reg_address_out=8'hFF.

## Configuration
- SPRDMA_ECS_EN defined: vstart/vstop are 10 bits, with CTL[6] giving vstart[9] and CTL[5] giving vstop[9]. Compares use vpos[9:0].
- SPRDMA_ECS_EN undefined: 9-bit vstart/vstop. CTL[6:5] are ignored and compares use vpos[8:0].

## Test plan
- VBSTOP pointer fetch:
  - Stimulus: write SPR0PTH=0x0001, SPR0PTL=0x2000; dmaena=1; vpos=25.
  - Required: at hpos 0x02A, dma=1, address_out=0x09000, reg_address_out=0xA0. At 0x02E, address 0x09001 and reg 0xA1. pt=0x09002 afterwards.
- Start/stop lines:
  - Stimulus: bus writes POS=0x4060, CTL=0x5000.
  - Required: line 0x40 fetches DATB (0xA3) then DATA (0xA2). Lines 0x41–0x4F fetch data. Line 0x50 fetches POS (0xA0) then CTL (0xA1).
- Sprite 7 slot position: sprite 7 in CTL state at VBSTOP issues its fetches at hpos 0x062 and 0x066 with reg 0xBC/0xBD. No other hpos asserts dma for it.
- dmaena low:
  - Stimulus: dmaena=0 across sprite 2's slots on an active line.
  - Required: dma stays 0, pt2 is unchanged and the state remains ACTIVE.
- Pointer write collision: SPR1PTL written in sprite 1's word-0 slot cycle leaves pt1 equal to the written value, not incremented.
- ECS macro:
  - Stimulus: POS=0x4000, CTL=0x0040.
  - Required: with SPRDMA_ECS_EN the data fetch starts at vpos 0x240, without it at 0x040.
- Mid-operation reset: reset asserted while sprite 3 is ACTIVE gives dma=0 and reg_address_out=0xFF on the next cycle. No fetch occurs on later lines until VBSTOP.

Source files
------------

// File: rtl/sprite_dma_if.sv
// sprite_dma_if: beam position, register bus snoop and chip-bus request
// signals between the sprite DMA engine and the rest of Agnus.
//   master : the sprite DMA engine (drives dma, address_out, reg_address_out)
//   slave  : beam counters / register bus / chip-bus arbiter side
interface sprite_dma_if;
  logic [8:0]  hpos;
  logic [10:0] vpos;
  logic        dmaena;
  logic [7:0]  reg_address_in;
  logic [15:0] data_in;
  logic        dma;
  logic [19:0] address_out;
  logic [7:0]  reg_address_out;

  modport master (
    input  hpos, vpos, dmaena, reg_address_in, data_in,
    output dma, address_out, reg_address_out
  );

  modport slave (
    output hpos, vpos, dmaena, reg_address_in, data_in,
    input  dma, address_out, reg_address_out
  );
endinterface

// File: rtl/sprite_dma.sv
// sprite_dma: Agnus sprite DMA engine. Holds SPRxPT pointers, snoops
// SPRxPOS/CTL writes for vstart/vstop, and runs a per-sprite vertical FSM that
// fetches POS/CTL or DATB/DATA pairs in fixed horizontal slots each line.
// Ports:
//   clk    : bus clock, one hpos step per cycle
//   reset  : synchronous, active-high
//   bus    : sprite_dma_if.master (hpos, vpos, dmaena, reg_address_in,
//            data_in in; dma, address_out, reg_address_out out)
// Option: define SPRDMA_ECS_EN for 10-bit vstart/vstop (CTL[6]/CTL[5]).
module sprite_dma (
  input  logic         clk,
  input  logic         reset,
  sprite_dma_if.master bus
);

  localparam int unsigned NSPR      = 8;
  localparam logic [8:0]  SLOT_BASE = 9'h02A;
  localparam logic [8:0]  SLOT_LAST = 9'd60;   // offset of sprite 7 word 1
  localparam logic [10:0] VBSTOP    = 11'd25;
`ifdef SPRDMA_ECS_EN
  localparam int unsigned VW = 10;
`else
  localparam int unsigned VW = 9;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CTL, S_WAIT, S_ACTIVE} spr_state_t;
  typedef enum logic [1:0] {A_NONE, A_CTL, A_DATA} act_t;

  spr_state_t    state_q  [NSPR];
  spr_state_t    state_d  [NSPR];
  logic [19:0]   pt_q     [NSPR];
  logic [19:0]   pt_d     [NSPR];
  logic [VW-1:0] vstart_q [NSPR];
  logic [VW-1:0] vstart_d [NSPR];
  logic [VW-1:0] vstop_q  [NSPR];
  logic [VW-1:0] vstop_d  [NSPR];

  // Line action latched at word 0, consumed at word 1 of the same sprite.
  logic       lat_valid_q, lat_valid_d;
  logic [2:0] lat_spr_q, lat_spr_d;
  act_t       lat_act_q, lat_act_d;
  spr_state_t lat_next_q, lat_next_d;

  logic [8:0]    off;
  logic          in_slot;
  logic [2:0]    spr;
  logic          word1;
  logic [VW-1:0] vcur;
  act_t          act0;
  spr_state_t    nxt0;
  act_t          cur_act;
  logic [1:0]    sel;
  logic          fetch;

  // Slot decode: sprite n owns offsets 8n (word 0) and 8n+4 (word 1).
  assign off     = bus.hpos - SLOT_BASE;
  assign in_slot = (bus.hpos >= SLOT_BASE) && (off <= SLOT_LAST) && (off[1:0] == 2'b00);
  assign spr     = off[5:3];
  assign word1   = off[2];
  assign vcur    = bus.vpos[VW-1:0];

  // Word-0 decision for the sprite owning the current slot, and fetch select.
  always_comb begin
    act0    = A_NONE;
    nxt0    = state_q[spr];
    cur_act = A_NONE;
    sel     = 2'd0;
    case (state_q[spr])
      S_CTL: begin
        act0 = A_CTL;
        nxt0 = S_WAIT;
      end
      S_WAIT: begin
        if (vcur == vstart_q[spr]) begin
          act0 = A_DATA;
          nxt0 = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (vcur == vstop_q[spr]) begin
          act0 = A_CTL;
          nxt0 = S_WAIT;
        end else begin
          act0 = A_DATA;
        end
      end
      default: ;
    endcase
    if (in_slot) begin
      if (!word1) begin
        cur_act = act0;
        sel     = (act0 == A_DATA) ? 2'd3 : 2'd0;   // DATB or POS
      end else if (lat_valid_q && (lat_spr_q == spr)) begin
        cur_act = lat_act_q;
        sel     = (lat_act_q == A_DATA) ? 2'd2 : 2'd1;  // DATA or CTL
      end
    end
  end

  assign fetch               = in_slot && bus.dmaena && (cur_act != A_NONE);
  assign bus.dma             = fetch;
  assign bus.address_out     = fetch ? pt_q[spr] : 20'd0;
  assign bus.reg_address_out = fetch ? {3'b101, spr, sel} : 8'hFF;

  // Next-state: FSM advance, VBSTOP force, pointer and snoop registers.
  always_comb begin
    state_d     = state_q;
    pt_d        = pt_q;
    vstart_d    = vstart_q;
    vstop_d     = vstop_q;
    lat_valid_d = lat_valid_q;
    lat_spr_d   = lat_spr_q;
    lat_act_d   = lat_act_q;
    lat_next_d  = lat_next_q;

    if (in_slot && !word1) begin
      // dmaena low at word 0 leaves the sprite untouched for this line.
      lat_valid_d = bus.dmaena;
      lat_spr_d   = spr;
      lat_act_d   = act0;
      lat_next_d  = nxt0;
    end else if (in_slot && word1) begin
      lat_valid_d = 1'b0;
      if (lat_valid_q && (lat_spr_q == spr)) state_d[spr] = lat_next_q;
    end

    if ((bus.hpos == 9'd0) && (bus.vpos == VBSTOP)) begin
      for (int unsigned i = 0; i < NSPR; i++) state_d[i] = S_CTL;
    end

    for (int unsigned i = 0; i < NSPR; i++) begin
      if (fetch && (spr == 3'(i))) pt_d[i] = pt_q[i] + 20'd1;
      // Bus writes override the increment on the halves they touch.
      if (bus.reg_address_in == {4'h9, 3'(i), 1'b0}) pt_d[i][19:15] = bus.data_in[4:0];
      if (bus.reg_address_in == {4'h9, 3'(i), 1'b1}) begin
        pt_d[i][14:0] = bus.data_in[15:1];
        if (bus.reg_address_in != {4'h9, 3'(i), 1'b0}) pt_d[i][19:15] = pt_q[i][19:15];
      end
      if (bus.reg_address_in == {3'b101, 3'(i), 2'd0}) vstart_d[i][7:0] = bus.data_in[15:8];
      if (bus.reg_address_in == {3'b101, 3'(i), 2'd1}) begin
        vstop_d[i][7:0] = bus.data_in[15:8];
        vstart_d[i][8]  = bus.data_in[2];
        vstop_d[i][8]   = bus.data_in[1];
`ifdef SPRDMA_ECS_EN
        vstart_d[i][9]  = bus.data_in[6];
        vstop_d[i][9]   = bus.data_in[5];
`endif
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NSPR; i++) begin
        state_q[i]  <= S_IDLE;
        pt_q[i]     <= '0;
        vstart_q[i] <= '0;
        vstop_q[i]  <= '0;
      end
      lat_valid_q <= 1'b0;
      lat_spr_q   <= '0;
      lat_act_q   <= A_NONE;
      lat_next_q  <= S_IDLE;
    end else begin
      state_q     <= state_d;
      pt_q        <= pt_d;
      vstart_q    <= vstart_d;
      vstop_q     <= vstop_d;
      lat_valid_q <= lat_valid_d;
      lat_spr_q   <= lat_spr_d;
      lat_act_q   <= lat_act_d;
      lat_next_q  <= lat_next_d;
    end
  end

endmodule

// File: tb/tb_sprite_dma.sv
// tb_sprite_dma: directed bench for sprite_dma. Inputs change 1 time unit
// after the rising edge; outputs are sampled 2 units later, mid-cycle.
module tb_sprite_dma;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sprite_dma_if bus ();

  sprite_dma dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [8:0] h, input logic [10:0] v, input logic en,
                       input logic [7:0] ra, input logic [15:0] d);
    bus.hpos           = h;
    bus.vpos           = v;
    bus.dmaena         = en;
    bus.reg_address_in = ra;
    bus.data_in        = d;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One slot cycle with full output check.
  task automatic slot(input string tag, input logic [8:0] h, input logic [10:0] v,
                      input logic en, input logic exp_dma, input logic [19:0] exp_addr,
                      input logic [7:0] exp_reg, input logic [7:0] ra = 8'hFF,
                      input logic [15:0] d = 16'h0000);
    drive(h, v, en, ra, d);
    chk($sformatf("%s dma", tag), 32'(bus.dma), 32'(exp_dma));
    chk($sformatf("%s addr", tag), 32'(bus.address_out), 32'(exp_addr));
    chk($sformatf("%s reg", tag), 32'(bus.reg_address_out), 32'(exp_reg));
    tick();
  endtask

  // Register bus write outside any slot.
  task automatic wr(input logic [7:0] ra, input logic [15:0] d);
    drive(9'h100, 11'd30, 1'b1, ra, d);
    tick();
  endtask

  task automatic vbstop();
    drive(9'd0, 11'd25, 1'b1, 8'hFF, 16'h0);
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.hpos = 9'h100; bus.vpos = 11'd0; bus.dmaena = 1'b0;
    bus.reg_address_in = 8'hFF; bus.data_in = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    slot("reset", 9'h02A, 11'd25, 1'b1, 1'b0, 20'h0, 8'hFF);
    reset = 1'b0;

    // Idle after reset: states are IDLE, no fetch in a slot.
    slot("idle", 9'h02A, 11'd30, 1'b1, 1'b0, 20'h0, 8'hFF);

    wr(8'h90, 16'h0001); wr(8'h91, 16'h2000);   // pt0 = 0x09000
    wr(8'h95, 16'h1000);                        // pt2 = 0x00800
    wr(8'h97, 16'h2000);                        // pt3 = 0x01000
    wr(8'h9F, 16'h0400);                        // pt7 = 0x00200

    vbstop();
    slot("vb s0w0", 9'h02A, 11'd25, 1'b1, 1'b1, 20'h09000, 8'hA0);
    slot("vb gap",  9'h02C, 11'd25, 1'b1, 1'b0, 20'h0,     8'hFF);
    slot("vb s0w1", 9'h02E, 11'd25, 1'b1, 1'b1, 20'h09001, 8'hA1);
    slot("vb s2w0", 9'h03A, 11'd25, 1'b1, 1'b1, 20'h00800, 8'hA8);
    slot("vb s2w1", 9'h03E, 11'd25, 1'b1, 1'b1, 20'h00801, 8'hA9);
    slot("vb s3w0", 9'h042, 11'd25, 1'b1, 1'b1, 20'h01000, 8'hAC);
    slot("vb s3w1", 9'h046, 11'd25, 1'b1, 1'b1, 20'h01001, 8'hAD);
    slot("vb s6w1 nolatch", 9'h05E, 11'd25, 1'b1, 1'b0, 20'h0, 8'hFF);
    slot("vb s7w0", 9'h062, 11'd25, 1'b1, 1'b1, 20'h00200, 8'hBC);
    slot("vb s7gap", 9'h064, 11'd25, 1'b1, 1'b0, 20'h0,    8'hFF);
    slot("vb s7w1", 9'h066, 11'd25, 1'b1, 1'b1, 20'h00201, 8'hBD);
    slot("vb past", 9'h06A, 11'd25, 1'b1, 1'b0, 20'h0,     8'hFF);

    wr(8'hA0, 16'h4060); wr(8'hA1, 16'h5000);   // spr0 vstart 0x40 vstop 0x50
    wr(8'hA8, 16'h4000); wr(8'hA9, 16'h5000);   // spr2
    wr(8'hAC, 16'h4000); wr(8'hAD, 16'h6000);   // spr3 vstop 0x60

    slot("l3f s0w0", 9'h02A, 11'h03F, 1'b1, 1'b0, 20'h0, 8'hFF);
    slot("l3f s0w1", 9'h02E, 11'h03F, 1'b1, 1'b0, 20'h0, 8'hFF);

    slot("l40 s0w0", 9'h02A, 11'h040, 1'b1, 1'b1, 20'h09002, 8'hA3);
    slot("l40 s0w1", 9'h02E, 11'h040, 1'b1, 1'b1, 20'h09003, 8'hA2);
    slot("l40 s2w0", 9'h03A, 11'h040, 1'b1, 1'b1, 20'h00802, 8'hAB);
    slot("l40 s2w1", 9'h03E, 11'h040, 1'b1, 1'b1, 20'h00803, 8'hAA);
    slot("l40 s3w0", 9'h042, 11'h040, 1'b1, 1'b1, 20'h01002, 8'hAF);
    slot("l40 s3w1", 9'h046, 11'h040, 1'b1, 1'b1, 20'h01003, 8'hAE);

    slot("l41 s0w0", 9'h02A, 11'h041, 1'b1, 1'b1, 20'h09004, 8'hA3);
    slot("l41 s0w1", 9'h02E, 11'h041, 1'b1, 1'b1, 20'h09005, 8'hA2);
    slot("l41 s2w0 off", 9'h03A, 11'h041, 1'b0, 1'b0, 20'h0, 8'hFF);
    slot("l41 s2w1 off", 9'h03E, 11'h041, 1'b0, 1'b0, 20'h0, 8'hFF);

    slot("l42 s2w0", 9'h03A, 11'h042, 1'b1, 1'b1, 20'h00804, 8'hAB);
    slot("l42 s2w1", 9'h03E, 11'h042, 1'b1, 1'b1, 20'h00805, 8'hAA);
    slot("l43 s2w0", 9'h03A, 11'h043, 1'b1, 1'b1, 20'h00806, 8'hAB);
    slot("l43 s2w1 cut", 9'h03E, 11'h043, 1'b0, 1'b0, 20'h0, 8'hFF);
    slot("l44 s2w0", 9'h03A, 11'h044, 1'b1, 1'b1, 20'h00807, 8'hAB);

    // SPR1PTL write in sprite 1's word-0 slot beats the increment.
    slot("l45 s1w0 wr", 9'h032, 11'h045, 1'b1, 1'b1, 20'h00000, 8'hA4, 8'h93, 16'h4000);
    slot("l45 s1w1",    9'h036, 11'h045, 1'b1, 1'b1, 20'h02000, 8'hA5);

    slot("l4f s0w0", 9'h02A, 11'h04F, 1'b1, 1'b1, 20'h09006, 8'hA3);
    slot("l4f s0w1", 9'h02E, 11'h04F, 1'b1, 1'b1, 20'h09007, 8'hA2);
    slot("l50 s0w0", 9'h02A, 11'h050, 1'b1, 1'b1, 20'h09008, 8'hA0);
    slot("l50 s0w1", 9'h02E, 11'h050, 1'b1, 1'b1, 20'h09009, 8'hA1);
    slot("l51 s0w0", 9'h02A, 11'h051, 1'b1, 1'b0, 20'h0,     8'hFF);

    // Reset asserted during sprite 3's active word-0 slot.
    reset = 1'b1;
    slot("l52 s3w0 rst", 9'h042, 11'h052, 1'b1, 1'b1, 20'h01004, 8'hAF);
    reset = 1'b0;
    slot("l52 s3w1 post", 9'h046, 11'h052, 1'b1, 1'b0, 20'h0, 8'hFF);
    slot("l53 s0w0 post", 9'h02A, 11'h053, 1'b1, 1'b0, 20'h0, 8'hFF);
    slot("l53 s3w0 post", 9'h042, 11'h053, 1'b1, 1'b0, 20'h0, 8'hFF);

    vbstop();
    slot("vb2 s3w0", 9'h042, 11'd25, 1'b1, 1'b1, 20'h00000, 8'hAC);
    slot("vb2 s4w0", 9'h04A, 11'd25, 1'b1, 1'b1, 20'h00000, 8'hB0);
    slot("vb2 s4w1", 9'h04E, 11'd25, 1'b1, 1'b1, 20'h00001, 8'hB1);

    wr(8'hB0, 16'h4000); wr(8'hB1, 16'h0040);   // CTL[6] is vstart[9] on ECS
`ifdef SPRDMA_ECS_EN
    slot("ecs l040 s4w0", 9'h04A, 11'h040, 1'b1, 1'b0, 20'h0, 8'hFF);
    slot("ecs l040 s4w1", 9'h04E, 11'h040, 1'b1, 1'b0, 20'h0, 8'hFF);
    slot("ecs l240 s4w0", 9'h04A, 11'h240, 1'b1, 1'b1, 20'h00002, 8'hB3);
    slot("ecs l240 s4w1", 9'h04E, 11'h240, 1'b1, 1'b1, 20'h00003, 8'hB2);
`else
    slot("ocs l040 s4w0", 9'h04A, 11'h040, 1'b1, 1'b1, 20'h00002, 8'hB3);
    slot("ocs l040 s4w1", 9'h04E, 11'h040, 1'b1, 1'b1, 20'h00003, 8'hB2);
    slot("ocs l240 s4w0", 9'h04A, 11'h240, 1'b1, 1'b1, 20'h00004, 8'hB3);
    slot("ocs l240 s4w1", 9'h04E, 11'h240, 1'b1, 1'b1, 20'h00005, 8'hB2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
